// File: rtl/dmux_8way.sv
// rtl/dmux_8way.sv - registered 1-to-8 demultiplexer; optional act[7:0] one-hot indicator under DMUX8WAY_ACT_EN
module dmux_8way #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       sel,
    input  logic             en,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
`ifdef DMUX8WAY_ACT_EN
    output logic [WIDTH-1:0] h,
    output logic [7:0]       act
`else
    output logic [WIDTH-1:0] h
`endif
);

    logic [7:0][WIDTH-1:0] chan;

    // Every channel reloads on a capture, so the previous destination clears on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan <= '0;
        end else if (en) begin
            for (int i = 0; i < 8; i++) begin
                chan[i] <= (sel == 3'(i)) ? in : '0;
            end
        end
    end

    assign a = chan[0];
    assign b = chan[1];
    assign c = chan[2];
    assign d = chan[3];
    assign e = chan[4];
    assign f = chan[5];
    assign g = chan[6];
    assign h = chan[7];

`ifdef DMUX8WAY_ACT_EN
    logic [7:0] act_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= '0;
        end else if (en) begin
            act_q <= 8'b1 << sel;
        end
    end

    assign act = act_q;
`endif

endmodule

// File: tb/tb_dmux_8way.sv
// tb/tb_dmux_8way.sv - directed self-checking bench for dmux_8way at WIDTH=16
module tb_dmux_8way;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in = '0;
    logic [2:0]   sel = '0;
    logic         en = 1'b0;
    logic [W-1:0] a, b, c, d, e, f, g, h;
`ifdef DMUX8WAY_ACT_EN
    logic [7:0]   act;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmux_8way #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .sel   (sel),
        .en    (en),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e     (e),
        .f     (f),
        .g     (g),
`ifdef DMUX8WAY_ACT_EN
        .h     (h),
        .act   (act)
`else
        .h     (h)
`endif
    );

    // Expected packed outputs {h..a}: only channel s carries v.
    function automatic logic [8*W-1:0] expect_out(input logic [2:0] s, input logic [W-1:0] v);
        logic [8*W-1:0] r;
        r = '0;
        r[s*W +: W] = v;
        return r;
    endfunction

    task automatic check_out(input string tag, input logic [8*W-1:0] exp_v);
        logic [8*W-1:0] obs;
        obs = {h, g, f, e, d, c, b, a};
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: outputs observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_act(input string tag, input logic [7:0] exp_a);
`ifdef DMUX8WAY_ACT_EN
        n_checks++;
        assert (act === exp_a) else begin
            n_fail++;
            $error("FAIL %s: act observed %b expected %b", tag, act, exp_a);
        end
`else
        if (tag.len() == 0 && exp_a == 8'hff) $display("unused");
`endif
    endtask

    task automatic capture(input logic [2:0] s, input logic [W-1:0] v, input logic enable);
        @(negedge clk);
        sel = s;
        in  = v;
        en  = enable;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        check_out("reset_state", '0);
        check_act("reset_act", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Released but en=0: outputs stay zero.
        capture(3'd4, 16'hFFFF, 1'b0);
        check_out("release_no_en", '0);
        check_act("release_no_en_act", 8'h00);

        for (int s = 0; s < 8; s++) begin
            capture(3'(s), 16'h0000, 1'b1);
            check_out($sformatf("zero_sweep_%0d", s), '0);
            check_act($sformatf("zero_sweep_act_%0d", s), 8'h01 << s);
        end

        for (int s = 0; s < 8; s++) begin
            capture(3'(s), 16'h0001, 1'b1);
            check_out($sformatf("one_sweep_%0d", s), expect_out(3'(s), 16'h0001));
            check_act($sformatf("one_sweep_act_%0d", s), 8'h01 << s);
        end

        capture(3'd5, 16'h0001, 1'b1);
        check_out("hold_load_f", expect_out(3'd5, 16'h0001));
        for (int k = 0; k < 3; k++) begin
            capture(3'd0, 16'h0000, 1'b0);
            check_out($sformatf("hold_%0d", k), expect_out(3'd5, 16'h0001));
            check_act($sformatf("hold_act_%0d", k), 8'h20);
        end

        capture(3'd2, 16'h0001, 1'b1);
        check_out("pre_reset_c", expect_out(3'd2, 16'h0001));
        @(negedge clk);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", '0);
        check_act("async_reset_act", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        capture(3'd0, 16'h0001, 1'b1);
        check_out("after_reset_a", expect_out(3'd0, 16'h0001));
        check_act("after_reset_act", 8'h01);

        capture(3'd6, 16'hA5C3, 1'b1);
        check_out("wide_g", expect_out(3'd6, 16'hA5C3));
        capture(3'd1, 16'hA5C3, 1'b1);
        check_out("wide_b", expect_out(3'd1, 16'hA5C3));
        check_act("wide_b_act", 8'h02);
        capture(3'd7, 16'h5A3C, 1'b1);
        check_out("wide_h", expect_out(3'd7, 16'h5A3C));
        capture(3'd3, 16'h8001, 1'b1);
        check_out("wide_d", expect_out(3'd3, 16'h8001));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
